// File: rtl/prio_pkg.sv
// ----------------------------------------------------------------------------
// prio_pkg
//   Shared constants and helpers for the priority-encoder family.
//
//   PRIO_N_MAX    largest supported request-vector width
//   prio_idx_w()  index width for an n-input encoder: ceil(log2(n)), min 1
// ----------------------------------------------------------------------------
package prio_pkg;

  localparam int PRIO_N_MAX = 64;

  function automatic int prio_idx_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage : prio_pkg

// File: rtl/prio_sel.sv
// ----------------------------------------------------------------------------
// prio_sel
//   Combinational selector: picks one set bit of vec, searching downward from
//   ptr (inclusive) and wrapping from 0 to N-1. With ptr = N-1 the search is
//   plain fixed priority (highest index wins).
//
//   Implementation: rotate vec so that bit ptr lands at position N-1, find
//   the highest set bit of the rotated vector, then map that position back.
//
// Ports
//   vec  in   N      candidate bits
//   ptr  in   IDX_W  index searched first (must be < N)
//   idx  out  IDX_W  selected index (0 when any = 0)
//   any  out  1      vec has at least one bit set
// ----------------------------------------------------------------------------
module prio_sel
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = prio_idx_w(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             sh;
  int             hit;
  int             src;
  logic           found;

  always_comb begin
    // Rotate right by (ptr+1) mod N: rot[j] = vec[(j + ptr + 1) mod N],
    // so rot[N-1] = vec[ptr] and descending rot order follows the search.
    sh = int'(ptr) + 1;
    if (sh >= N) begin
      sh = 0;
    end
    dbl = {vec, vec} >> sh;
    rot = dbl[N-1:0];

    hit   = 0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (rot[j]) begin
        hit   = j;
        found = 1'b1;
      end
    end

    src = hit + sh;
    if (src >= N) begin
      src = src - N;
    end

    idx = found ? IDX_W'(src) : '0;
    any = found;
  end

endmodule : prio_sel

// File: rtl/prio_enc_arb.sv
// ----------------------------------------------------------------------------
// prio_enc_arb
//   Registered N-input priority encoder with sticky request capture and a
//   valid/ready output. Every request bit is held in 'pending' until its index
//   has been loaded into the output register, so a stalled consumer never
//   loses an event. Each captured request is encoded exactly once.
//
//   Build option:
//     PRIO_ENC_RR_EN  defined   -> round-robin selection
//                     undefined -> fixed priority, bit N-1 highest
//
// Ports
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   req        in   N      request pulses, captured every cycle
//   out_idx    out  IDX_W  index of the held request (registered)
//   out_valid  out  1      out_idx holds an un-consumed request
//   out_ready  in   1      consumer takes out_idx when out_valid && out_ready
//   pending    out  N      captured requests not yet loaded into the output
//   busy       out  1      |pending || out_valid, from registers only
// ----------------------------------------------------------------------------
module prio_enc_arb
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = prio_idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     pending,
  output logic             busy
);

  if (N < 2 || N > PRIO_N_MAX) begin : g_bad_n
    $error("prio_enc_arb: N out of supported range");
  end

  logic [N-1:0]     pending_q, pending_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  logic [N-1:0]     cand;
  logic             load;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic [IDX_W-1:0] ptr_cur;
  logic [N-1:0]     sel_mask;

  assign cand = pending_q | req;
  // The output register may be (re)loaded when empty or being consumed now.
  assign load = !valid_q || out_ready;

`ifdef PRIO_ENC_RR_EN
  // ptr_q holds the index searched first. After a grant it moves to just
  // below the granted index, so the next search runs sel-1, sel-2, ... and
  // wraps, reaching sel itself last. Reset value N-1 makes the first grant
  // identical to fixed priority.
  logic [IDX_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load && sel_any) begin
      if (sel_idx == '0) begin
        ptr_d = IDX_W'(N - 1);
      end else begin
        ptr_d = sel_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_cur = ptr_q;
`else
  assign ptr_cur = IDX_W'(N - 1);
`endif

  prio_sel #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_sel (
    .vec (cand),
    .ptr (ptr_cur),
    .idx (sel_idx),
    .any (sel_any)
  );

  assign sel_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;

  always_comb begin
    pending_d = pending_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    if (load) begin
      if (sel_any) begin
        idx_d     = sel_idx;
        valid_d   = 1'b1;
        pending_d = cand & ~sel_mask;
      end else begin
        // Nothing to encode: out_idx keeps its last value.
        valid_d   = 1'b0;
        pending_d = '0;
      end
    end else begin
      // Stalled: output holds, new requests (including a re-request of the
      // held index) accumulate in pending.
      pending_d = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
    end
  end

  assign out_idx   = idx_q;
  assign out_valid = valid_q;
  assign pending   = pending_q;
  assign busy      = (|pending_q) || valid_q;

endmodule : prio_enc_arb

// File: tb/tb_prio_enc_arb.sv
module tb_prio_enc_arb;

  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [IW-1:0] out_idx;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  pending;
  logic          busy;

  always #5 clk = ~clk;

  prio_enc_arb #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pending   (pending),
    .busy      (busy)
  );

  typedef struct {
    logic          rst_n;
    logic [N-1:0]  req;
    logic          rdy;
    logic          v;
    logic [IW-1:0] idx;
    logic [N-1:0]  pend;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [N-1:0] p_m;
  int           cap[N];
  int           acc[N];

  task automatic add(input logic r, input logic [N-1:0] q, input logic rd,
                     input logic v, input logic [IW-1:0] i, input logic [N-1:0] p);
    vec_t t;
    t.rst_n = r; t.req = q; t.rdy = rd; t.v = v; t.idx = i; t.pend = p;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int hi(input logic [N-1:0] v);
    int h;
    h = -1;
    for (int i = 0; i < N; i++) if (v[i]) h = i;
    return h;
  endfunction

  task automatic rnd_cycle(input logic [N-1:0] rq, input logic rd);
    logic          pv;
    logic [IW-1:0] pi;
    logic [N-1:0]  cand;
    logic          ld;
    req = rq; out_ready = rd;
    pv = out_valid; pi = out_idx;
    cand = p_m | rq;
    ld = !pv || rd;
    for (int i = 0; i < N; i++) if (rq[i] && !p_m[i]) cap[i]++;
    if (pv && rd) acc[pi]++;
    step();
    if (ld) begin
      if (cand != '0) begin
        chk("rnd_valid", out_valid, 1'b1);
        chk("rnd_idx_in_cand", cand[out_idx], 1'b1);
`ifndef PRIO_ENC_RR_EN
        chk("rnd_prio", out_idx, hi(cand));
`endif
        p_m = cand & ~(8'd1 << out_idx);
      end else begin
        chk("rnd_idle", out_valid, 1'b0);
        p_m = '0;
      end
    end else begin
      chk("rnd_hold_valid", out_valid, 1'b1);
      chk("rnd_hold_idx", out_idx, pi);
      p_m = cand;
    end
    chk("rnd_pending", pending, p_m);
    chk("rnd_busy", busy, (|p_m) || out_valid);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; out_ready = 1'b0;

    // reset
    add(0, 8'h00, 0, 0, 0, 8'h00);
    add(0, 8'h00, 0, 0, 0, 8'h00);
    // idle after reset
    for (int i = 0; i < 5; i++) add(1, 8'h00, 1, 0, 0, 8'h00);
    // single pulse with two bits, consumer always ready
    add(1, 8'h24, 1, 1, 5, 8'h04);
    add(1, 8'h00, 1, 1, 2, 8'h00);
    add(1, 8'h00, 1, 0, 2, 8'h00);
    add(1, 8'h00, 1, 0, 2, 8'h00);
    // reset, then stalled consumer
    add(0, 8'h00, 1, 0, 0, 8'h00);
    add(1, 8'h81, 0, 1, 7, 8'h01);
    for (int i = 0; i < 10; i++) add(1, 8'h00, 0, 1, 7, 8'h01);
    add(1, 8'h00, 1, 1, 0, 8'h00);
    add(1, 8'h00, 1, 0, 0, 8'h00);
    // reset mid-stall discards pending work
    add(1, 8'h1F, 0, 1, 4, 8'h0F);
    add(0, 8'h00, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) add(1, 8'h00, 1, 0, 0, 8'h00);
    // re-request of held index is encoded a second time
    add(1, 8'h08, 0, 1, 3, 8'h00);
    add(1, 8'h08, 0, 1, 3, 8'h08);
    add(1, 8'h00, 1, 1, 3, 8'h00);
    add(1, 8'h00, 1, 0, 3, 8'h00);
    // accept and new request of the same index in one cycle
    add(1, 8'h02, 0, 1, 1, 8'h00);
    add(1, 8'h02, 1, 1, 1, 8'h00);
    add(1, 8'h00, 1, 0, 1, 8'h00);
    // repeats of a pending bit merge
    add(1, 8'h10, 0, 1, 4, 8'h00);
    add(1, 8'h01, 0, 1, 4, 8'h01);
    add(1, 8'h01, 0, 1, 4, 8'h01);
    add(1, 8'h00, 1, 1, 0, 8'h00);
    add(1, 8'h00, 1, 0, 0, 8'h00);

    for (int k = 0; k < vecs.size(); k++) begin
      rst_n = vecs[k].rst_n; req = vecs[k].req; out_ready = vecs[k].rdy;
      step();
      chk($sformatf("vec%0d_valid", k), out_valid, vecs[k].v);
      chk($sformatf("vec%0d_idx", k), out_idx, vecs[k].idx);
      chk($sformatf("vec%0d_pending", k), pending, vecs[k].pend);
      chk($sformatf("vec%0d_busy", k), busy, (|vecs[k].pend) || vecs[k].v);
    end

    // all requests held, consumer always ready
    rst_n = 1'b0; req = '0; out_ready = 1'b0;
    step();
    rst_n = 1'b1; req = 8'hFF; out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk($sformatf("allreq%0d_valid", k), out_valid, 1'b1);
`ifdef PRIO_ENC_RR_EN
      chk($sformatf("allreq%0d_idx", k), out_idx, (15 - k) % 8);
`else
      chk($sformatf("allreq%0d_idx", k), out_idx, 7);
`endif
    end

    // random traffic against the capture/consume scoreboard
    req = '0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    p_m = '0;
    for (int i = 0; i < N; i++) begin cap[i] = 0; acc[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      rnd_cycle(8'($urandom_range(0, 255) & $urandom_range(0, 255)),
                $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 20; c++) rnd_cycle(8'h00, 1'b1);
    chk("drain_busy", busy, 1'b0);
    for (int i = 0; i < N; i++) chk($sformatf("count_idx%0d", i), acc[i], cap[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_prio_enc_arb
